mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 205 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage.
//
// Holds one instruction from EXE. It either finishes at once (ALU op, or an op
// whose request was suppressed by an exception) or waits for the data-SRAM
// response. Load data is latched, then the addressed byte or half is extracted
// and sign- or zero-extended. When a flush (cancel_exc_ertn) abandons an
// instruction whose response is still in flight, a 2-bit drop counter records
// that response so it is discarded later and not taken as the answer to a
// younger load.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   exe_to_mem_valid           EXE offers an instruction
//   mem_allowin                MEM can accept that instruction this cycle
//   exe_pc, exe_result         PC and ALU result / memory address
//   exe_res_from_mem           instruction is a load
//   exe_mem_all[7:0]           {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
//   exe_mem_req                EXE issued a data-SRAM request
//   exe_rf_all[5:0]            {rf_we, rf_waddr[4:0]}
//   exe_exc_rf[5:0]            exception flags (pass-through)
//   exe_csr_rf[78:0]           CSR bundle (pass-through); bit 78 = csr_wr,
//                              bits 77:64 = csr_wr_num
//   data_sram_data_ok/_rdata   SRAM response strobe and data
//   wb_allowin                 WB accepts this cycle
//   cancel_exc_ertn            flush from exception / ertn
//   mem_to_wb_valid            result offered to WB
//   mem_valid                  stage occupied
//   mem_pc, mem_result         PC and final writeback value
//   mem_rf_all, mem_exc_rf,    registered pass-through bundles
//   mem_csr_rf
//   mem_fwd_all[53:0]          {csr_wr, csr_wr_num[13:0], mem_wait, rf_we,
//                               rf_waddr[4:0], mem_result}
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_to_mem_valid,
    output logic        mem_allowin,
    input  logic [31:0] exe_pc,
    input  logic [31:0] exe_result,
    input  logic        exe_res_from_mem,
    input  logic [7:0]  exe_mem_all,
    input  logic        exe_mem_req,
    input  logic [5:0]  exe_rf_all,
    input  logic [5:0]  exe_exc_rf,
    input  logic [78:0] exe_csr_rf,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    input  logic        cancel_exc_ertn,
    output logic        mem_to_wb_valid,
    output logic        mem_valid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_result,
    output logic [5:0]  mem_rf_all,
    output logic [53:0] mem_fwd_all,
    output logic [5:0]  mem_exc_rf,
    output logic [78:0] mem_csr_rf
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_drop_cnt;

    logic [31:0] r_pc;
    logic [31:0] r_result;
    logic        r_res_from_mem;
    logic        r_ld_b;
    logic        r_ld_h;
    logic        r_ld_se;
    logic [31:0] r_rdata;
    logic [5:0]  r_rf_all;
    logic [5:0]  r_exc_rf;
    logic [78:0] r_csr_rf;

    logic        w_capture;
    logic        w_req_eff;
    logic        w_dok_accept;
    logic        w_dok_dropped;
    logic        w_orphan;
    logic        w_mem_wait;
    logic [31:0] w_load_data;
    logic        w_unused;

    // Pick the addressed byte/half out of the response word and extend it.
    // ld_w (or no size flag) passes the whole word through.
    function automatic logic [31:0] load_extract(
        input logic [31:0] rdata,
        input logic [1:0]  addr,
        input logic        ld_b,
        input logic        ld_h,
        input logic        ld_se
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (addr)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        if (ld_b)
            res = {{24{ld_se & b[7]}}, b};
        else if (ld_h)
            res = {{16{ld_se & h[15]}}, h};
        else
            res = rdata;
        return res;
    endfunction

    assign mem_valid       = (r_state != S_EMPTY);
    assign mem_to_wb_valid = (r_state == S_DONE);
    assign mem_allowin     = (r_state == S_EMPTY) | ((r_state == S_DONE) & wb_allowin);
    assign w_mem_wait      = (r_state == S_WAIT);

    // A flush blocks capture in the same cycle.
    assign w_capture = exe_to_mem_valid & mem_allowin & ~cancel_exc_ertn;

    // A pending exception means the request never reached the SRAM.
    assign w_req_eff = exe_mem_req & ~(|exe_exc_rf);

    // Responses arriving while the drop counter is non-zero belong to
    // abandoned instructions; only a response with the counter at zero is
    // the answer for the instruction waiting here.
    assign w_dok_dropped = data_sram_data_ok & (r_drop_cnt != 2'd0);
    assign w_dok_accept  = data_sram_data_ok & (r_drop_cnt == 2'd0) & (r_state == S_WAIT);

    // Flushing a waiting instruction leaves its response in flight, unless
    // that response is arriving in this very cycle.
    assign w_orphan = cancel_exc_ertn & (r_state == S_WAIT) & ~w_dok_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_drop_cnt <= 2'd0;
        end else begin
            case ({w_orphan, w_dok_dropped})
                2'b10:   if (r_drop_cnt != 2'd3) r_drop_cnt <= r_drop_cnt + 2'd1;
                2'b01:   r_drop_cnt <= r_drop_cnt - 2'd1;
                default: r_drop_cnt <= r_drop_cnt;
            endcase

            if (cancel_exc_ertn)
                r_state <= S_EMPTY;
            else if (w_capture)
                r_state <= w_req_eff ? S_WAIT : S_DONE;
            else if (w_dok_accept)
                r_state <= S_DONE;
            else if ((r_state == S_DONE) && wb_allowin)
                r_state <= S_EMPTY;
        end
    end

    // Instruction payload: only meaningful while the stage is occupied.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_pc           <= exe_pc;
            r_result       <= exe_result;
            r_res_from_mem <= exe_res_from_mem;
            r_ld_b         <= exe_mem_all[6];
            r_ld_h         <= exe_mem_all[5];
            r_ld_se        <= exe_mem_all[3];
        end
        if (w_dok_accept && !cancel_exc_ertn)
            r_rdata <= data_sram_rdata;
    end

    // Bundles seen by later stages start from a known zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_all <= 6'd0;
            r_exc_rf <= 6'd0;
            r_csr_rf <= 79'd0;
        end else if (w_capture) begin
            r_rf_all <= exe_rf_all;
            r_exc_rf <= exe_exc_rf;
            r_csr_rf <= exe_csr_rf;
        end
    end

    assign w_load_data = load_extract(r_rdata, r_result[1:0], r_ld_b, r_ld_h, r_ld_se);

    assign mem_pc     = r_pc;
    assign mem_result = r_res_from_mem ? w_load_data : r_result;
    assign mem_rf_all = r_rf_all;
    assign mem_exc_rf = r_exc_rf;
    assign mem_csr_rf = r_csr_rf;

    // Write enables are qualified by occupancy so an empty stage never
    // claims a register; mem_wait makes ID stall instead of forwarding.
    assign mem_fwd_all = {mem_valid & r_csr_rf[78], r_csr_rf[77:64], w_mem_wait,
                          mem_valid & r_rf_all[5], r_rf_all[4:0], mem_result};

    // Store-size flags and mem_we are consumed by EXE, not here.
    assign w_unused = ^{exe_mem_all[7], exe_mem_all[4], exe_mem_all[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] exe_pc;
    logic [31:0] exe_result;
    logic        exe_res_from_mem;
    logic [7:0]  exe_mem_all;
    logic        exe_mem_req;
    logic [5:0]  exe_rf_all;
    logic [5:0]  exe_exc_rf;
    logic [78:0] exe_csr_rf;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        cancel_exc_ertn;
    logic        mem_to_wb_valid;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_result;
    logic [5:0]  mem_rf_all;
    logic [53:0] mem_fwd_all;
    logic [5:0]  mem_exc_rf;
    logic [78:0] mem_csr_rf;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .mem_allowin       (mem_allowin),
        .exe_pc            (exe_pc),
        .exe_result        (exe_result),
        .exe_res_from_mem  (exe_res_from_mem),
        .exe_mem_all       (exe_mem_all),
        .exe_mem_req       (exe_mem_req),
        .exe_rf_all        (exe_rf_all),
        .exe_exc_rf        (exe_exc_rf),
        .exe_csr_rf        (exe_csr_rf),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_allowin        (wb_allowin),
        .cancel_exc_ertn   (cancel_exc_ertn),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_valid         (mem_valid),
        .mem_pc            (mem_pc),
        .mem_result        (mem_result),
        .mem_rf_all        (mem_rf_all),
        .mem_fwd_all       (mem_fwd_all),
        .mem_exc_rf        (mem_exc_rf),
        .mem_csr_rf        (mem_csr_rf)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        reset             = 1'b0;
        exe_to_mem_valid  = 1'b0;
        exe_pc            = 32'd0;
        exe_result        = 32'd0;
        exe_res_from_mem  = 1'b0;
        exe_mem_all       = 8'd0;
        exe_mem_req       = 1'b0;
        exe_rf_all        = 6'd0;
        exe_exc_rf        = 6'd0;
        exe_csr_rf        = 79'd0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        wb_allowin        = 1'b1;
        cancel_exc_ertn   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic rfm,
                         input logic [7:0] mall, input logic req, input logic [5:0] rf,
                         input logic [5:0] exc, input logic [78:0] csr);
        exe_to_mem_valid = 1'b1;
        exe_pc           = pc;
        exe_result       = res;
        exe_res_from_mem = rfm;
        exe_mem_all      = mall;
        exe_mem_req      = req;
        exe_rf_all       = rf;
        exe_exc_rf       = exc;
        exe_csr_rf       = csr;
        tick();
        exe_to_mem_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = d;
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    // Directed single-transaction vectors (expected values worked by hand).
    typedef struct {
        logic        rfm;
        logic [7:0]  mall;
        logic [31:0] addr;
        logic        req;
        logic [5:0]  exc;
        logic [31:0] rdata;
        logic        exp_wait;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[11];

    // Behavioural reference model state (transaction level).
    bit          m_occ;
    bit          m_wait;
    int          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_res;
    logic [31:0] m_rdata;
    logic        m_rfm;
    logic [7:0]  m_mall;
    logic [5:0]  m_rf;
    logic [5:0]  m_exc;
    logic [78:0] m_csr;

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] a,
                                             input logic [7:0] mall);
        int unsigned v;
        int unsigned sh;
        if (mall[6]) begin
            sh = 8 * int'(a);
            v  = (d >> sh) & 32'hFF;
            if (mall[3] && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (mall[5]) begin
            sh = 16 * int'(a[1]);
            v  = (d >> sh) & 32'hFFFF;
            if (mall[3] && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_occ  = 0;
        m_wait = 0;
        m_drop = 0;
        m_rf   = 6'd0;
        m_exc  = 6'd0;
        m_csr  = 79'd0;
    endtask

    initial begin
        logic        e_allow;
        logic        accept;
        logic [21:0] e_fwd_hi;
        logic [31:0] e_res;

        vecs[0]  = '{1'b1, 8'h10, 32'h0000_0100, 1'b1, 6'h00, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 8'h48, 32'h0000_1003, 1'b1, 6'h00, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 8'h40, 32'h0000_2001, 1'b1, 6'h00, 32'h1234_A5CD, 1'b1, 32'h0000_00A5};
        vecs[3]  = '{1'b1, 8'h48, 32'h0000_3000, 1'b1, 6'h00, 32'h0000_007F, 1'b1, 32'h0000_007F};
        vecs[4]  = '{1'b1, 8'h48, 32'h0000_4002, 1'b1, 6'h00, 32'h00C3_0000, 1'b1, 32'hFFFF_FFC3};
        vecs[5]  = '{1'b1, 8'h20, 32'h0000_5002, 1'b1, 6'h00, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF};
        vecs[6]  = '{1'b1, 8'h28, 32'h0000_6000, 1'b1, 6'h00, 32'h0000_8001, 1'b1, 32'hFFFF_8001};
        vecs[7]  = '{1'b1, 8'h28, 32'h0000_7002, 1'b1, 6'h00, 32'h7FFF_1234, 1'b1, 32'h0000_7FFF};
        vecs[8]  = '{1'b0, 8'h81, 32'hCAFE_0004, 1'b1, 6'h00, 32'h1111_1111, 1'b1, 32'hCAFE_0004};
        vecs[9]  = '{1'b0, 8'h00, 32'h1234_5678, 1'b0, 6'h00, 32'h0000_0000, 1'b0, 32'h1234_5678};
        vecs[10] = '{1'b0, 8'h10, 32'h0BAD_0000, 1'b1, 6'h04, 32'h0000_0000, 1'b0, 32'h0BAD_0000};

        clear_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // ---------------- reset state ----------------
        chk("rst_valid",   80'(mem_valid), 80'(0));
        chk("rst_towb",    80'(mem_to_wb_valid), 80'(0));
        chk("rst_allowin", 80'(mem_allowin), 80'(1));
        chk("rst_rf_all",  80'(mem_rf_all), 80'(0));
        chk("rst_exc",     80'(mem_exc_rf), 80'(0));
        chk("rst_csr",     80'(mem_csr_rf), 80'(0));

        // ---------------- ALU op, single cycle ----------------
        issue(32'h1C00_0000, 32'h1234_5678, 1'b0, 8'h00, 1'b0, 6'h25, 6'h00, 79'd0);
        chk("alu_towb",   80'(mem_to_wb_valid), 80'(1));
        chk("alu_result", 80'(mem_result), 80'(32'h1234_5678));
        chk("alu_rf_all", 80'(mem_rf_all), 80'(6'h25));
        chk("alu_pc",     80'(mem_pc), 80'(32'h1C00_0000));
        chk("alu_fwd_rf", 80'(mem_fwd_all[37:32]), 80'(6'h25));
        tick();
        chk("alu_empty",  80'(mem_valid), 80'(0));

        // ---------------- table of single transactions ----------------
        for (int i = 0; i < 11; i++) begin
            issue(32'h1000 + 32'(i * 4), vecs[i].addr, vecs[i].rfm, vecs[i].mall,
                  vecs[i].req, 6'h11, vecs[i].exc, 79'd0);
            chk($sformatf("vec%0d_wait", i), 80'(mem_fwd_all[38]), 80'(vecs[i].exp_wait));
            if (vecs[i].exp_wait)
                respond(vecs[i].rdata);
            chk($sformatf("vec%0d_towb", i), 80'(mem_to_wb_valid), 80'(1));
            chk($sformatf("vec%0d_result", i), 80'(mem_result), 80'(vecs[i].exp_res));
            chk($sformatf("vec%0d_exc", i), 80'(mem_exc_rf), 80'(vecs[i].exc));
            tick();
            chk($sformatf("vec%0d_empty", i), 80'(mem_valid), 80'(0));
        end

        // ---------------- ld_b signed, response after 3 wait cycles ----------------
        issue(32'h2000, 32'h0000_1003, 1'b1, 8'h48, 1'b1, 6'h22, 6'h00, 79'd0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("ldb_wait%0d", c), 80'(mem_fwd_all[38]), 80'(1));
            chk($sformatf("ldb_allow%0d", c), 80'(mem_allowin), 80'(0));
            chk($sformatf("ldb_towb%0d", c), 80'(mem_to_wb_valid), 80'(0));
            if (c == 2) respond(32'h80FF_0000);
            else tick();
        end
        chk("ldb_wait_clr", 80'(mem_fwd_all[38]), 80'(0));
        chk("ldb_result",   80'(mem_result), 80'(32'hFFFF_FF80));
        tick();

        // ---------------- ld_h unsigned, WB back-pressure ----------------
        issue(32'h2004, 32'h0000_2002, 1'b1, 8'h20, 1'b1, 6'h23, 6'h00, 79'd0);
        wb_allowin = 1'b0;
        respond(32'hBEEF_0000);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("ldh_hold_res%0d", c), 80'(mem_result), 80'(32'h0000_BEEF));
            chk($sformatf("ldh_hold_allow%0d", c), 80'(mem_allowin), 80'(0));
            chk($sformatf("ldh_hold_towb%0d", c), 80'(mem_to_wb_valid), 80'(1));
            tick();
        end
        wb_allowin = 1'b1;
        #1;
        chk("ldh_allow_on", 80'(mem_allowin), 80'(1));
        tick();
        chk("ldh_empty", 80'(mem_valid), 80'(0));

        // ---------------- cancel while waiting, stale response dropped ----------------
        issue(32'h3000, 32'h0000_0040, 1'b1, 8'h10, 1'b1, 6'h24, 6'h00, 79'd0);
        cancel_exc_ertn = 1'b1;
        tick();
        cancel_exc_ertn = 1'b0;
        chk("cxl_empty", 80'(mem_valid), 80'(0));
        issue(32'h3004, 32'h0000_0080, 1'b1, 8'h10, 1'b1, 6'h25, 6'h00, 79'd0);
        respond(32'hAAAA_AAAA);
        chk("cxl_drop_wait", 80'(mem_fwd_all[38]), 80'(1));
        chk("cxl_drop_towb", 80'(mem_to_wb_valid), 80'(0));
        respond(32'h5555_5555);
        chk("cxl_towb",   80'(mem_to_wb_valid), 80'(1));
        chk("cxl_result", 80'(mem_result), 80'(32'h5555_5555));
        tick();

        // ---------------- cancel in the same cycle as the response ----------------
        issue(32'h4000, 32'h0000_0100, 1'b1, 8'h10, 1'b1, 6'h26, 6'h00, 79'd0);
        cancel_exc_ertn = 1'b1;
        respond(32'hDDDD_DDDD);
        cancel_exc_ertn = 1'b0;
        chk("cxd_empty", 80'(mem_valid), 80'(0));
        respond(32'hEEEE_EEEE);
        chk("cxd_ignored", 80'(mem_valid), 80'(0));
        issue(32'h4004, 32'h0000_0104, 1'b1, 8'h10, 1'b1, 6'h27, 6'h00, 79'd0);
        respond(32'h1357_9BDF);
        chk("cxd_towb",   80'(mem_to_wb_valid), 80'(1));
        chk("cxd_result", 80'(mem_result), 80'(32'h1357_9BDF));
        tick();

        // ---------------- reset while waiting, overriding cancel and capture ----------------
        issue(32'h5000, 32'h0000_0200, 1'b1, 8'h10, 1'b1, 6'h28, 6'h01, 79'd0);
        issue(32'h5004, 32'h0000_0204, 1'b1, 8'h10, 1'b1, 6'h29, 6'h00, 79'd0);
        chk("rw_wait", 80'(mem_fwd_all[38]), 80'(1));
        reset            = 1'b1;
        cancel_exc_ertn  = 1'b1;
        exe_to_mem_valid = 1'b1;
        tick();
        reset            = 1'b0;
        cancel_exc_ertn  = 1'b0;
        exe_to_mem_valid = 1'b0;
        chk("rw_valid",   80'(mem_valid), 80'(0));
        chk("rw_allowin", 80'(mem_allowin), 80'(1));
        chk("rw_rf_all",  80'(mem_rf_all), 80'(0));
        issue(32'h5008, 32'h0000_0208, 1'b1, 8'h10, 1'b1, 6'h2A, 6'h00, 79'd0);
        respond(32'h0F0F_0F0F);
        chk("rw_cnt0_towb",   80'(mem_to_wb_valid), 80'(1));
        chk("rw_cnt0_result", 80'(mem_result), 80'(32'h0F0F_0F0F));
        tick();

        // ---------------- randomized traffic vs. reference model ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            exe_to_mem_valid  = ($urandom_range(0, 9) < 6);
            exe_pc            = $urandom;
            exe_result        = $urandom;
            exe_mem_all       = 8'($urandom);
            exe_mem_req       = ($urandom_range(0, 9) < 6);
            exe_exc_rf        = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            exe_res_from_mem  = exe_mem_req && (exe_exc_rf == 6'd0) && $urandom_range(0, 1) == 1;
            exe_rf_all        = 6'($urandom);
            exe_csr_rf        = {15'($urandom), $urandom, $urandom};
            data_sram_data_ok = ($urandom_range(0, 99) < 35);
            data_sram_rdata   = $urandom;
            wb_allowin        = ($urandom_range(0, 9) < 7);
            cancel_exc_ertn   = ($urandom_range(0, 11) == 0) && (m_drop < 3);
            reset             = ($urandom_range(0, 79) == 0);
            #1;

            e_allow  = !m_occ || (!m_wait && wb_allowin);
            e_fwd_hi = {m_occ & m_csr[78], m_csr[77:64], m_occ & m_wait, m_occ & m_rf[5], m_rf[4:0]};
            chk("rnd_allowin", 80'(mem_allowin), 80'(e_allow));
            chk("rnd_valid",   80'(mem_valid), 80'(m_occ));
            chk("rnd_towb",    80'(mem_to_wb_valid), 80'(m_occ && !m_wait));
            chk("rnd_fwd_hi",  80'(mem_fwd_all[53:32]), 80'(e_fwd_hi));
            chk("rnd_rf_all",  80'(mem_rf_all), 80'(m_rf));
            chk("rnd_exc",     80'(mem_exc_rf), 80'(m_exc));
            chk("rnd_csr",     80'(mem_csr_rf), 80'(m_csr));
            if (m_occ)
                chk("rnd_pc", 80'(mem_pc), 80'(m_pc));
            if (m_occ && !m_wait) begin
                e_res = m_rfm ? ref_load(m_rdata, m_res[1:0], m_mall) : m_res;
                chk("rnd_result",  80'(mem_result), 80'(e_res));
                chk("rnd_fwd_res", 80'(mem_fwd_all[31:0]), 80'(e_res));
            end

            @(posedge clk);
            if (reset) begin
                model_reset();
            end else begin
                accept = 1'b0;
                if (data_sram_data_ok) begin
                    if (m_drop > 0) m_drop--;
                    else if (m_occ && m_wait) accept = 1'b1;
                end
                if (cancel_exc_ertn) begin
                    if (m_occ && m_wait && !accept) m_drop++;
                    m_occ = 0;
                end else if (accept) begin
                    m_wait  = 0;
                    m_rdata = data_sram_rdata;
                end else if (e_allow && exe_to_mem_valid) begin
                    m_occ  = 1;
                    m_wait = exe_mem_req && (exe_exc_rf == 6'd0);
                    m_pc   = exe_pc;
                    m_res  = exe_result;
                    m_rfm  = exe_res_from_mem;
                    m_mall = exe_mem_all;
                    m_rf   = exe_rf_all;
                    m_exc  = exe_exc_rf;
                    m_csr  = exe_csr_rf;
                end else if (m_occ && !m_wait && wb_allowin) begin
                    m_occ = 0;
                end
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
